// File: rtl/heart_rate_meter.sv
// Beats-per-minute meter: counts beat edges in 1 s buckets, keeps a WINDOW_S-deep
// ring of buckets and scales the window total by 60/WINDOW_S.
module heart_rate_meter #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int WINDOW_S = 15,
    parameter int CNT_W    = 6,
    parameter int BPM_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             beat_in,
    output logic [BPM_W-1:0] bpm,
    output logic             bpm_valid,
    output logic             sat
);

    localparam int PRE_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int PTR_W   = (WINDOW_S > 1) ? $clog2(WINDOW_S) : 1;
    localparam int FILL_W  = $clog2(WINDOW_S + 1);
    localparam int SUM_MAX = WINDOW_S * (2 ** CNT_W - 1);
    localparam int SUM_W   = $clog2(SUM_MAX + 1);
    localparam int SCALE   = 60 / WINDOW_S;
    localparam int PROD_W  = (SUM_W + 7 > BPM_W + 1) ? SUM_W + 7 : BPM_W + 1;
    localparam int BPM_MAX = 2 ** BPM_W - 1;

    if (60 % WINDOW_S != 0) begin : g_bad_window
        $error("heart_rate_meter: WINDOW_S must divide 60");
    end

    logic [PRE_W-1:0]  presc;
    logic              beat_q;
    logic [CNT_W-1:0]  sec_cnt;
    logic [CNT_W-1:0]  ring [WINDOW_S];
    logic [PTR_W-1:0]  wr_ptr;
    logic [FILL_W-1:0] fill;
    logic [SUM_W-1:0]  sum;
    logic              upd_q;

    logic              sec_tick;
    logic              beat;
    logic              cnt_full;
    logic [CNT_W-1:0]  closing;
    logic              ptr_last;
    logic [FILL_W-1:0] fill_next;
    logic [SUM_W-1:0]  sum_next;
    logic              update_due;
    logic [PROD_W-1:0] bpm_full;
    logic              clip;

    assign sec_tick  = (presc == PRE_W'(CLK_HZ - 1));
    assign beat      = beat_in & ~beat_q;
    assign cnt_full  = &sec_cnt;
    // A beat landing on the tick cycle is folded into the second that is closing.
    assign closing   = (beat && !cnt_full) ? sec_cnt + CNT_W'(1) : sec_cnt;
    assign ptr_last  = (wr_ptr == PTR_W'(WINDOW_S - 1));
    assign fill_next = (fill == FILL_W'(WINDOW_S)) ? fill : fill + FILL_W'(1);
    assign sum_next  = sum + SUM_W'(closing) - SUM_W'(ring[wr_ptr]);
    assign update_due = mode ? (fill_next == FILL_W'(WINDOW_S)) : ptr_last;
    assign bpm_full  = PROD_W'(sum) * PROD_W'(SCALE);
    assign clip      = (bpm_full > PROD_W'(BPM_MAX));

    // bpm_valid is a single-cycle strobe, raised the cycle after a due tick,
    // with bpm already holding the new value in that same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            presc     <= '0;
            beat_q    <= 1'b0;
            sec_cnt   <= '0;
            for (int i = 0; i < WINDOW_S; i++) ring[i] <= '0;
            wr_ptr    <= '0;
            fill      <= '0;
            sum       <= '0;
            upd_q     <= 1'b0;
            bpm       <= '0;
            bpm_valid <= 1'b0;
            sat       <= 1'b0;
        end else begin
            beat_q    <= beat_in;
            bpm_valid <= 1'b0;
            if (beat && cnt_full) sat <= 1'b1;
            if (sec_tick) begin
                presc        <= '0;
                ring[wr_ptr] <= closing;
                sum          <= sum_next;
                wr_ptr       <= ptr_last ? '0 : wr_ptr + PTR_W'(1);
                fill         <= fill_next;
                sec_cnt      <= '0;
                upd_q        <= update_due;
            end else begin
                presc <= presc + PRE_W'(1);
                upd_q <= 1'b0;
                if (beat && !cnt_full) sec_cnt <= sec_cnt + CNT_W'(1);
            end
            if (upd_q) begin
                bpm       <= clip ? BPM_W'(BPM_MAX) : bpm_full[BPM_W-1:0];
                bpm_valid <= 1'b1;
                if (clip) sat <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_heart_rate_meter.sv
// Bench for heart_rate_meter: steady-rate vector table, hand-written corner
// sequences and a randomized run checked every cycle against a queue-based model.
module tb_heart_rate_meter;

    localparam int CLK_HZ = 10;
    localparam int WIN    = 15;
    localparam int CNT_W  = 6;
    localparam int BPM_W  = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             mode = 1'b0;
    logic             beat_in = 1'b0;
    logic [BPM_W-1:0] bpm;
    logic             bpm_valid;
    logic             sat;

    int errors = 0;
    int checks = 0;
    int ccount = 0;

    heart_rate_meter #(
        .CLK_HZ(CLK_HZ), .WINDOW_S(WIN), .CNT_W(CNT_W), .BPM_W(BPM_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .beat_in(beat_in),
        .bpm(bpm), .bpm_valid(bpm_valid), .sat(sat)
    );

    always #5 clk = ~clk;

    // cycle number since the last clear; the clearing edge itself is cycle 0
    always @(posedge clk) begin
        if (!rst_n || !en) ccount <= 0;
        else ccount <= ccount + 1;
    end

    // reference model: closed seconds are kept in a queue, window = last WIN entries
    int hist[$];
    int m_sub, m_cur, m_nsec, m_bpm, total, v;
    bit m_valid, m_sat, m_prev, m_pend;

    always @(posedge clk) begin
        if (!rst_n || !en) begin
            hist.delete();
            m_sub = 0; m_cur = 0; m_nsec = 0; m_bpm = 0;
            m_valid = 0; m_sat = 0; m_prev = 0; m_pend = 0;
        end else begin
            m_valid = 0;
            if (m_pend) begin
                total = 0;
                foreach (hist[i]) total += hist[i];
                v = total * (60 / WIN);
                if (v > 2 ** BPM_W - 1) begin v = 2 ** BPM_W - 1; m_sat = 1; end
                m_bpm = v;
                m_valid = 1;
            end
            m_pend = 0;
            if (beat_in && !m_prev) begin
                if (m_cur == 2 ** CNT_W - 1) m_sat = 1;
                else m_cur++;
            end
            m_prev = beat_in;
            if (m_sub == CLK_HZ - 1) begin
                hist.push_back(m_cur);
                if (hist.size() > WIN) void'(hist.pop_front());
                m_nsec++;
                m_cur = 0;
                m_sub = 0;
                m_pend = mode ? (m_nsec >= WIN) : (m_nsec % WIN == 0);
            end else begin
                m_sub++;
            end
        end
    end

    // scoreboard: every cycle against the model, plus a log of valid strobes
    int valid_cyc[$];
    int valid_bpm[$];
    logic [BPM_W-1:0] m_bpm_w;

    always @(posedge clk) begin
        #1;
        m_bpm_w = m_bpm[BPM_W-1:0];
        checks++;
        if ({bpm, bpm_valid, sat} !== {m_bpm_w, m_valid, m_sat}) begin
            errors++;
            $display("FAIL model cyc=%0d: dut bpm=%0d valid=%b sat=%b, model bpm=%0d valid=%b sat=%b",
                     ccount, bpm, bpm_valid, sat, m_bpm, m_valid, m_sat);
        end
        if (bpm_valid === 1'b1) begin
            valid_cyc.push_back(ccount);
            valid_bpm.push_back(int'(bpm));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // rate beats per second, placed on even phases of each second
    function automatic bit pat(input int rate, input int c);
        int ph;
        ph = c % CLK_HZ;
        return (ph % 2 == 0) && (ph / 2 < rate);
    endfunction

    task automatic run(input int n, input int rate);
        repeat (n) begin
            beat_in = pat(rate, ccount);
            @(negedge clk);
        end
    endtask

    task automatic do_clear(input bit use_rst);
        if (use_rst) rst_n = 1'b0;
        else en = 1'b0;
        beat_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        valid_cyc.delete();
        valid_bpm.delete();
    endtask

    typedef struct {
        bit mode;
        int rate;
        int cycles;
        int nvalid;
        int first;
        int last_bpm;
        bit sat;
    } vec_t;

    vec_t tbl[6];
    int   r;

    initial begin
        tbl[0] = '{1'b0, 1, 310, 2, 151, 60,  1'b0};
        tbl[1] = '{1'b1, 1, 200, 5, 151, 60,  1'b0};
        tbl[2] = '{1'b1, 5, 200, 5, 151, 255, 1'b1};
        tbl[3] = '{1'b0, 3, 160, 1, 151, 180, 1'b0};
        tbl[4] = '{1'b1, 4, 200, 5, 151, 240, 1'b0};
        tbl[5] = '{1'b0, 0, 160, 1, 151, 0,   1'b0};

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset bpm", int'(bpm), 0);
        chk("reset valid", int'(bpm_valid), 0);
        chk("reset sat", int'(sat), 0);

        // steady-rate vectors
        for (int i = 0; i < 6; i++) begin
            mode = tbl[i].mode;
            do_clear(1'b0);
            run(tbl[i].cycles, tbl[i].rate);
            chk($sformatf("vec%0d nvalid", i), valid_cyc.size(), tbl[i].nvalid);
            chk($sformatf("vec%0d first", i), qget(valid_cyc, 0), tbl[i].first);
            chk($sformatf("vec%0d bpm", i), int'(bpm), tbl[i].last_bpm);
            chk($sformatf("vec%0d sat", i), int'(sat), int'(tbl[i].sat));
        end

        // held-high level counts once; beat on the last tick counts in the closing second
        mode = 1'b1;
        do_clear(1'b0);
        run(2, 0);
        beat_in = 1'b1;
        repeat (25) @(negedge clk);
        beat_in = 1'b0;
        while (ccount < 149) @(negedge clk);
        beat_in = 1'b1;
        @(negedge clk);
        beat_in = 1'b0;
        while (ccount < 165) @(negedge clk);
        chk("edge first cyc", qget(valid_cyc, 0), 151);
        chk("edge first bpm", qget(valid_bpm, 0), 8);
        chk("edge second cyc", qget(valid_cyc, 1), 161);
        chk("edge second bpm", qget(valid_bpm, 1), 4);

        // synchronous reset from a saturated state, then a fresh warm-up
        mode = 1'b0;
        do_clear(1'b0);
        run(223, 5);
        chk("pre-rst sat", int'(sat), 1);
        do_clear(1'b1);
        chk("rst bpm", int'(bpm), 0);
        chk("rst valid", int'(bpm_valid), 0);
        chk("rst sat", int'(sat), 0);
        run(160, 1);
        chk("rst nvalid", valid_cyc.size(), 1);
        chk("rst first", qget(valid_cyc, 0), 151);
        chk("rst bpm60", qget(valid_bpm, 0), 60);

        // sat is sticky until en drops
        mode = 1'b1;
        do_clear(1'b0);
        run(200, 5);
        run(40, 0);
        chk("sticky bpm", int'(bpm), 240);
        chk("sticky sat", int'(sat), 1);
        do_clear(1'b0);
        chk("en-clr sat", int'(sat), 0);
        chk("en-clr bpm", int'(bpm), 0);
        chk("en-clr valid", int'(bpm_valid), 0);

        // sliding ramp: 1 beat/s then 2 beats/s
        mode = 1'b1;
        do_clear(1'b0);
        run(150, 1);
        run(156, 2);
        chk("ramp nvalid", valid_cyc.size(), 16);
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("ramp cyc%0d", j), qget(valid_cyc, j), 151 + 10 * j);
            chk($sformatf("ramp bpm%0d", j), qget(valid_bpm, j), 60 + 4 * j);
        end

        // block -> sliding at 20 s without a warm-up restart
        mode = 1'b0;
        do_clear(1'b0);
        run(200, 1);
        mode = 1'b1;
        run(60, 1);
        chk("toggle nvalid", valid_cyc.size(), 6);
        chk("toggle first", qget(valid_cyc, 0), 151);
        for (int j = 1; j < 6; j++) begin
            chk($sformatf("toggle cyc%0d", j), qget(valid_cyc, j), 211 + 10 * (j - 1));
            chk($sformatf("toggle bpm%0d", j), qget(valid_bpm, j), 60);
        end

        // randomized run, compared every cycle against the model
        mode = 1'b0;
        do_clear(1'b0);
        for (int c = 0; c < 4000; c++) begin
            r = $urandom_range(0, 999);
            if (r < 1) rst_n = 1'b0;
            else if (r < 2) en = 1'b0;
            else begin rst_n = 1'b1; en = 1'b1; end
            if ($urandom_range(0, 99) < 1) mode = ~mode;
            beat_in = ($urandom_range(0, 99) < 45);
            @(negedge clk);
        end
        rst_n = 1'b1;
        en = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
